// File: rtl/yadro_pkg.sv
// Shared types and constants for the yadro result path (yadro_equation -> yadro_result_buffer).
package yadro_pkg;

  localparam int YADRO_WIDTH = 32;
  localparam int DROP_CNT_W  = 16;

  typedef logic signed [YADRO_WIDTH-1:0] yadro_data_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/yadro_result_buffer_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module yadro_result_buffer_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic [AW-1:0]           raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/yadro_result_buffer.sv
// Burst-absorbing FWFT FIFO behind yadro_equation with sticky loss flag.
// Optional saturating drop counter enabled by YADRO_RESULT_BUFFER_DROP_CNT_EN.
module yadro_result_buffer
  import yadro_pkg::*;
#(
  parameter int WIDTH = YADRO_WIDTH,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    res_vld,
  input  logic signed [WIDTH-1:0] res,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic signed [WIDTH-1:0] out_data,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    full,
  output logic                    overflow
`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, drop;
  logic signed [WIDTH-1:0] rd_data;

  assign out_vld  = (fill_q != '0);
  assign full     = (fill_q == (AW+1)'(DEPTH));
  assign fill     = fill_q;
  assign overflow = overflow_q;

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
  assign pop  = out_vld & out_rdy;
  assign push = res_vld & (~full | pop);
  assign drop = res_vld & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  yadro_result_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~rst),
    .waddr (wr_ptr_q),
    .wdata (res),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign out_data = out_vld ? rd_data : '0;

`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_yadro_result_buffer.sv
// Bench for yadro_result_buffer: directed scenarios plus random traffic against a queue model.
module tb_yadro_result_buffer;
  import yadro_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    res_vld;
  logic signed [WIDTH-1:0] res;
  logic                    out_vld;
  logic                    out_rdy;
  logic signed [WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0]  fill;
  logic                    full;
  logic                    overflow;
`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0]   drop_cnt;
`endif

  yadro_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .res_vld  (res_vld),
    .res      (res),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .fill     (fill),
    .full     (full),
    .overflow (overflow)
`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  yadro_data_t m_q[$];
  bit          m_ovf;
  int          m_drop;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    yadro_data_t exp_data;
    exp_data = (m_q.size() != 0) ? m_q[0] : '0;
    check_eq("out_vld",  64'(out_vld),  64'(m_q.size() != 0));
    check_eq("out_data", 64'(out_data), 64'(exp_data));
    check_eq("fill",     64'(fill),     64'(m_q.size()));
    check_eq("full",     64'(full),     64'(m_q.size() == DEPTH));
    check_eq("overflow", 64'(overflow), 64'(m_ovf));
`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
    check_eq("drop_cnt", 64'(drop_cnt), 64'((m_drop > 65535) ? 65535 : m_drop));
`endif
  endtask

  // Called at a negedge: apply inputs, advance the model by one edge, then check.
  task automatic cycle(input bit v, input int d, input bit r, input bit rs);
    bit do_pop, do_push;
    res_vld = v;
    res     = d;
    out_rdy = r;
    rst     = rs;
    if (rs) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
    end else begin
      do_pop  = r && (m_q.size() != 0);
      do_push = v && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(yadro_data_t'(d));
      if (v && !do_push) begin
        m_ovf = 1'b1;
        m_drop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; res_vld = 1'b0; res = '0; out_rdy = 1'b0;
    @(negedge clk);
    do_reset();
    check_eq("rst_out_vld", 64'(out_vld), 64'd0);
    check_eq("rst_fill", 64'(fill), 64'd0);

    // Single pass
    cycle(1, -7, 1, 0);
    check_eq("single_vld", 64'(out_vld), 64'd1);
    check_eq("single_data", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFF9);
    cycle(0, 0, 1, 0);
    check_eq("single_fill0", 64'(fill), 64'd0);

    // Burst and drain
    do_reset();
    for (int k = 1; k <= 8; k++) cycle(1, k, 0, 0);
    check_eq("burst_full", 64'(full), 64'd1);
    check_eq("burst_fill", 64'(fill), 64'd8);
    check_eq("burst_ovf", 64'(overflow), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      check_eq("burst_drain", 64'(out_data), 64'(k));
      cycle(0, 0, 1, 0);
    end
    check_eq("burst_empty_vld", 64'(out_vld), 64'd0);
    check_eq("burst_empty_data", 64'(out_data), 64'd0);

    // Overflow
    do_reset();
    for (int k = 1; k <= 8; k++) cycle(1, k, 0, 0);
    cycle(1, 100, 0, 0);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("ovf_fill", 64'(fill), 64'd8);
`ifdef YADRO_RESULT_BUFFER_DROP_CNT_EN
    check_eq("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    for (int k = 1; k <= 8; k++) begin
      check_eq("ovf_drain", 64'(out_data), 64'(k));
      cycle(0, 0, 1, 0);
    end
    check_eq("ovf_empty", 64'(out_vld), 64'd0);
    check_eq("ovf_sticky", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop
    do_reset();
    for (int k = 1; k <= 8; k++) cycle(1, k, 0, 0);
    cycle(1, 9, 1, 0);
    check_eq("pp_fill", 64'(fill), 64'd8);
    check_eq("pp_ovf", 64'(overflow), 64'd0);
    for (int k = 2; k <= 9; k++) begin
      check_eq("pp_drain", 64'(out_data), 64'(k));
      cycle(0, 0, 1, 0);
    end

    // Wrap-around
    do_reset();
    for (int k = 0; k < 20; k++) begin
      cycle(1, k, 1, 0);
      check_eq("wrap_data", 64'(out_data), 64'(k));
      check_eq("wrap_fill_le1", 64'(fill <= 1), 64'd1);
    end
    cycle(0, 0, 1, 0);

    // Reset mid-operation
    do_reset();
    for (int k = 1; k <= 5; k++) cycle(1, k, 0, 0);
    cycle(1, 77, 0, 1);
    check_eq("midrst_fill", 64'(fill), 64'd0);
    check_eq("midrst_vld", 64'(out_vld), 64'd0);
    check_eq("midrst_ovf", 64'(overflow), 64'd0);
    cycle(1, 42, 0, 0);
    check_eq("midrst_42", 64'(out_data), 64'd42);

    // Random traffic with phases of low/high consumer readiness
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  rdy_pct;
      bit  v, r, rs;
      rdy_pct = ((i / 200) % 3 == 0) ? 15 : (((i / 200) % 3 == 1) ? 85 : 50);
      v  = ($urandom_range(99) < 70);
      r  = ($urandom_range(99) < rdy_pct);
      rs = ($urandom_range(499) == 0);
      cycle(v, int'($urandom), r, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
